// File: rtl/buffer_drain_arbiter.sv
// Round-robin drain of four BRAM buffers into fixed-length Avalon DRAM write bursts.
// Each buffer owns a contiguous DRAM region; a 4-entry FIFO decouples BRAM read latency from DRAM back-pressure.
module buffer_drain_arbiter #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [3:0]        BRAM_ready_mask,
  output logic [3:0]        BRAM_rd_request,
  input  logic              BRAM_rd_valid,
  input  logic [DATA_W-1:0] BRAM_rd_data,
  output logic [2:0]        BRAM_Sel,
  input  logic              DRAM_Wait_Request,
  output logic              DRAM_Write_Enable,
  output logic              DRAM_Write_Burst_Begin,
  output logic [4:0]        DRAM_Write_Burst_Count,
  output logic [ADDR_W-1:0] DRAM_Write_Addr,
  output logic [DATA_W-1:0] DRAM_Write_Data,
  output logic              busy,
  output logic [15:0]       bursts_done
);

  localparam int OFF_W = ADDR_W - 2;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(BURST_LEN);
  localparam logic [OFF_W-1:0] OFF_STEP  = OFF_W'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, GRANT, XFER, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [1:0]        rst_sync;
  logic              run;
  logic [1:0]        rr_ptr, sel, pick;
  logic              pick_ok;
  logic [CNT_W-1:0]  req_cnt, acc_cnt;
  logic [2:0]        outstanding, fifo_count;
  logic [1:0]        wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_mem [4];
  logic [OFF_W-1:0]  offset [4];
  logic              overflow;
  logic              issue, push, pop, fifo_full, last_beat;

  // Reset release is retimed so nothing starts within two cycles of rst_n rising.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  // Beats still in flight from a reset-aborted burst arrive with outstanding==0 and are dropped.
  assign fifo_full = (fifo_count == 3'd4);
  assign issue     = (state == XFER) && (req_cnt != ALL_BEATS)
                     && ((4'(outstanding) + 4'(fifo_count)) < 4'd4);
  assign push      = BRAM_rd_valid && (outstanding != 3'd0);
  assign pop       = (fifo_count != 3'd0) && !DRAM_Wait_Request;
  assign last_beat = (state == DRAIN) && pop && (acc_cnt == LAST_BEAT);

  // NOTE: always_comb gives every output a default first, so no path can infer a latch.
  always_comb begin
    pick    = rr_ptr;
    pick_ok = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (BRAM_ready_mask[rr_ptr + 2'(i)]) begin
        pick    = rr_ptr + 2'(i);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // A sticky overflow means the datapath is corrupt; stop starting new bursts.
      IDLE:  if (run && enable && (BRAM_ready_mask != 4'd0) && !overflow) state_nxt = GRANT;
      GRANT: state_nxt = pick_ok ? XFER : IDLE;
      XFER:  if (issue && (req_cnt == LAST_BEAT)) state_nxt = DRAIN;
      DRAIN: if (last_beat)
               state_nxt = (enable && (BRAM_ready_mask != 4'd0)) ? GRANT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 2'd0;
      sel         <= 2'd0;
      req_cnt     <= '0;
      acc_cnt     <= '0;
      outstanding <= 3'd0;
      fifo_count  <= 3'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      bursts_done <= 16'd0;
      overflow    <= 1'b0;
      for (int i = 0; i < 4; i++) offset[i] <= '0;
    end else begin
      if (state == GRANT && pick_ok) begin
        sel     <= pick;
        rr_ptr  <= pick + 2'd1;
        req_cnt <= '0;
        acc_cnt <= '0;
      end else begin
        if (issue) req_cnt <= req_cnt + CNT_W'(1);
        if (pop)   acc_cnt <= acc_cnt + CNT_W'(1);
      end

      case ({issue, push})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase

      if (push) begin
        if (fifo_full) overflow <= 1'b1;
        else           wr_ptr   <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + 3'(push && !fifo_full) - 3'(pop);

      if (last_beat) begin
        bursts_done <= bursts_done + 16'd1;
        offset[sel] <= offset[sel] + OFF_STEP;
      end
    end
  end

  // NOTE: FIFO storage has no reset; fifo_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !fifo_full) fifo_mem[wr_ptr] <= BRAM_rd_data;
  end

  // Every DRAM output derives from registers that only move on an accepted beat, so they hold under wait.
  assign BRAM_rd_request        = issue ? (4'b0001 << sel) : 4'b0000;
  assign BRAM_Sel               = {1'b0, sel};
  assign DRAM_Write_Enable      = (fifo_count != 3'd0);
  assign DRAM_Write_Burst_Begin = DRAM_Write_Enable && (acc_cnt == '0);
  assign DRAM_Write_Burst_Count = 5'(BURST_LEN);
  assign DRAM_Write_Addr        = {sel, offset[sel]};
  assign DRAM_Write_Data        = fifo_mem[rd_ptr];
  assign busy                   = (state != IDLE);

endmodule
